// File: rtl/lin_resp_rx.sv
// LIN response receiver: deserialises 8 data bytes plus checksum from sdo_resp,
// recomputes the classic/enhanced checksum and flags checksum and framing errors.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for rx_en and a falling edge on the line
// S_START | half-bit wait, then confirm the start bit is still low
// S_DATA  | eight full-bit samples, shifted in LSB first
// S_STOP  | full-bit wait, then check the stop bit and commit the byte
// S_GAP   | inter-byte idle, bounded by the timeout counter
module lin_resp_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ENHANCED     = 1,
  parameter int TIMEOUT_BITS = 14
) (
  input  logic        sys_clk,
  input  logic        rstn,
  input  logic        rx_en,
  input  logic [5:0]  pid,
  input  logic        sdo_resp,
  output logic [63:0] data_out,
  output logic [7:0]  chk_out,
  output logic        resp_valid,
  output logic        chk_err,
  output logic        frame_err,
  output logic        busy
);

  localparam int TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW      = $clog2(TMO_CYC + 1);

  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TMO_LD  = CW'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t        state, state_n;
  logic          prev;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [3:0]    byte_idx, byte_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    acc, acc_n;
  logic [63:0]   data_out_n;
  logic [7:0]    chk_out_n;
  logic          resp_valid_n, chk_err_n, frame_err_n;

  logic          edge_det;
  logic          cnt_zero;
  logic [7:0]    pid_prot;
  logic [8:0]    sum9;
  logic [7:0]    acc_fold;

  assign edge_det = prev & ~sdo_resp;
  assign cnt_zero = (cnt == '0);
  assign pid_prot = {~(pid[1] ^ pid[3] ^ pid[4] ^ pid[5]),
                     pid[0] ^ pid[1] ^ pid[2] ^ pid[4],
                     pid};
  // End-around carry: a 9-bit sum above 255 folds back as sum - 255.
  assign sum9     = {1'b0, acc} + {1'b0, shreg};
  assign acc_fold = sum9[8] ? (sum9[7:0] + 8'd1) : sum9[7:0];
  assign busy     = (state != S_IDLE);

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      prev       <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      acc        <= '0;
      data_out   <= '0;
      chk_out    <= '0;
      resp_valid <= 1'b0;
      chk_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      prev       <= sdo_resp;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      byte_idx   <= byte_idx_n;
      shreg      <= shreg_n;
      acc        <= acc_n;
      data_out   <= data_out_n;
      chk_out    <= chk_out_n;
      resp_valid <= resp_valid_n;
      chk_err    <= chk_err_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    byte_idx_n   = byte_idx;
    shreg_n      = shreg;
    acc_n        = acc;
    data_out_n   = data_out;
    chk_out_n    = chk_out;
    resp_valid_n = 1'b0;
    chk_err_n    = chk_err;
    frame_err_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_en && edge_det) begin
          state_n    = S_START;
          cnt_n      = HALF_LD;
          byte_idx_n = '0;
          acc_n      = (ENHANCED != 0) ? pid_prot : 8'h00;
        end
      end

      S_START: begin
        if (cnt_zero) begin
          if (!sdo_resp) begin
            state_n   = S_DATA;
            cnt_n     = BIT_LD;
            bit_idx_n = '0;
          end else begin
            state_n     = S_IDLE;
            frame_err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_zero) begin
          shreg_n = {sdo_resp, shreg[7:1]};
          cnt_n   = BIT_LD;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_zero) begin
          if (!sdo_resp) begin
            state_n     = S_IDLE;
            frame_err_n = 1'b1;
          end else if (byte_idx == 4'd8) begin
            state_n      = S_IDLE;
            chk_out_n    = shreg;
            chk_err_n    = (shreg != ~acc);
            resp_valid_n = 1'b1;
          end else begin
            data_out_n[{byte_idx[2:0], 3'b000} +: 8] = shreg;
            acc_n      = acc_fold;
            byte_idx_n = byte_idx + 4'd1;
            cnt_n      = TMO_LD;
            state_n    = S_GAP;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end

      S_GAP: begin
        // Timeout wins over an edge arriving in the same cycle.
        if (cnt_zero) begin
          state_n     = S_IDLE;
          frame_err_n = 1'b1;
        end else if (edge_det) begin
          state_n = S_START;
          cnt_n   = HALF_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lin_resp_rx.sv
// Directed bench for lin_resp_rx: an enhanced and a classic instance share one
// serial line; pulses are tallied on the falling clock edge.
`timescale 1ns/1ps
module tb_lin_resp_rx;

  localparam int CPB = 16;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_en = 1'b0;
  logic [5:0]  pid  = 6'h2d;
  logic        sdo  = 1'b1;

  logic [63:0] data_out_e, data_out_c;
  logic [7:0]  chk_out_e, chk_out_c;
  logic        resp_valid_e, resp_valid_c;
  logic        chk_err_e, chk_err_c;
  logic        frame_err_e, frame_err_c;
  logic        busy_e, busy_c;

  lin_resp_rx #(.CLKS_PER_BIT(CPB), .ENHANCED(1), .TIMEOUT_BITS(14)) dut_e (
    .sys_clk(clk), .rstn(rstn), .rx_en(rx_en), .pid(pid), .sdo_resp(sdo),
    .data_out(data_out_e), .chk_out(chk_out_e), .resp_valid(resp_valid_e),
    .chk_err(chk_err_e), .frame_err(frame_err_e), .busy(busy_e)
  );

  lin_resp_rx #(.CLKS_PER_BIT(CPB), .ENHANCED(0), .TIMEOUT_BITS(14)) dut_c (
    .sys_clk(clk), .rstn(rstn), .rx_en(rx_en), .pid(pid), .sdo_resp(sdo),
    .data_out(data_out_c), .chk_out(chk_out_c), .resp_valid(resp_valid_c),
    .chk_err(chk_err_c), .frame_err(frame_err_c), .busy(busy_c)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   rv_e = 0, fe_e = 0, rv_c = 0, fe_c = 0, both = 0;
  logic ce_e, ce_c;
  int   k;

  always @(negedge clk) begin
    if (resp_valid_e) begin rv_e++; ce_e = chk_err_e; end
    if (resp_valid_c) begin rv_c++; ce_c = chk_err_c; end
    if (frame_err_e) fe_e++;
    if (frame_err_c) fe_c++;
    if ((resp_valid_e && frame_err_e) || (resp_valid_c && frame_err_c)) both++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    sdo = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sdo = b[i];
      repeat (CPB) @(negedge clk);
    end
    sdo = stop;
    repeat (CPB) @(negedge clk);
    sdo = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    sdo = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] d, input logic [7:0] chk);
    for (int i = 0; i < 8; i++) send_byte(d[8*i +: 8], 1'b1);
    send_byte(chk, 1'b1);
  endtask

  initial begin
    // Reset state
    #500;
    check("rst_data", data_out_e, 64'h0);
    check("rst_chk", {56'h0, chk_out_e}, 64'h0);
    check("rst_rv", {63'h0, resp_valid_e}, 64'h0);
    check("rst_fe", {63'h0, frame_err_e}, 64'h0);
    check("rst_busy", {63'h0, busy_e}, 64'h0);
    @(negedge clk);
    rstn  = 1'b1;
    rx_en = 1'b1;
    idle_bits(2);

    // Frame with enhanced checksum 0x53
    send_frame(64'd32639, 8'h53);
    idle_bits(2);
    check("t1_rv_cnt", 64'(rv_e), 64'd1);
    check("t1_data", data_out_e, 64'h0000_0000_0000_7F7F);
    check("t1_chk_out", {56'h0, chk_out_e}, 64'h53);
    check("t1_chk_err", {63'h0, ce_e}, 64'h0);
    check("t1_fe_cnt", 64'(fe_e), 64'd0);
    check("t1_busy", {63'h0, busy_e}, 64'h0);
    check("t1_cls_rv", 64'(rv_c), 64'd1);
    check("t1_cls_err", {63'h0, ce_c}, 64'h1);

    // Same data with classic checksum 0x01
    send_frame(64'd32639, 8'h01);
    idle_bits(2);
    check("t2_cls_rv", 64'(rv_c), 64'd2);
    check("t2_cls_err", {63'h0, ce_c}, 64'h0);
    check("t2_cls_chk", {56'h0, chk_out_c}, 64'h01);
    check("t2_cls_fe", 64'(fe_c), 64'd0);
    check("t2_enh_err", {63'h0, ce_e}, 64'h1);

    // Falling edge ignored while disarmed
    rx_en = 1'b0;
    sdo = 1'b0;
    repeat (5) @(negedge clk);
    sdo = 1'b1;
    check("dis_busy", {63'h0, busy_e}, 64'h0);
    idle_bits(2);
    check("dis_fe", 64'(fe_e), 64'd0);
    rx_en = 1'b1;

    // Bad stop bit on the third byte
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle_bits(2);
    check("t3_fe_cnt", 64'(fe_e), 64'd1);
    check("t3_rv_cnt", 64'(rv_e), 64'd2);
    check("t3_data", data_out_e, 64'h0000_0000_0000_2211);
    check("t3_busy", {63'h0, busy_e}, 64'h0);

    // Short glitch: start bit reads high at mid-bit
    sdo = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_busy_hi", {63'h0, busy_e}, 64'h1);
    sdo = 1'b1;
    idle_bits(2);
    check("t4_fe_cnt", 64'(fe_e), 64'd2);
    check("t4_busy", {63'h0, busy_e}, 64'h0);
    check("t4_rv_cnt", 64'(rv_e), 64'd2);

    // Inter-byte timeout after the fourth byte
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    k = 0;
    while (!frame_err_e && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("t5_tmo_cyc", 64'(k), 64'd217);
    idle_bits(1);
    check("t5_fe_cnt", 64'(fe_e), 64'd3);
    check("t5_busy", {63'h0, busy_e}, 64'h0);
    check("t5_data", data_out_e, 64'h0000_0000_D4C3_B2A1);
    check("t5_rv_cnt", 64'(rv_e), 64'd2);

    // 13-bit gap is tolerated
    send_byte(8'h7F, 1'b1);
    send_byte(8'h7F, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    idle_bits(13);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
    send_byte(8'h53, 1'b1);
    idle_bits(2);
    check("t5g_rv_cnt", 64'(rv_e), 64'd3);
    check("t5g_fe_cnt", 64'(fe_e), 64'd3);
    check("t5g_chk_err", {63'h0, ce_e}, 64'h0);
    check("t5g_data", data_out_e, 64'h0000_0000_0000_7F7F);

    // Asynchronous reset in the middle of byte 5
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    sdo = 1'b0;
    repeat (CPB) @(negedge clk);
    sdo = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_data", data_out_e, 64'h0);
    check("t6_rst_chk", {56'h0, chk_out_e}, 64'h0);
    check("t6_rst_busy", {63'h0, busy_e}, 64'h0);
    check("t6_rst_rv", {63'h0, resp_valid_e}, 64'h0);
    check("t6_rst_fe", {63'h0, frame_err_e}, 64'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle_bits(2);
    send_frame(64'd32639, 8'h53);
    idle_bits(2);
    check("t6_rv_cnt", 64'(rv_e), 64'd4);
    check("t6_fe_cnt", 64'(fe_e), 64'd3);
    check("t6_data", data_out_e, 64'h0000_0000_0000_7F7F);
    check("t6_chk_out", {56'h0, chk_out_e}, 64'h53);
    check("t6_chk_err", {63'h0, ce_e}, 64'h0);

    check("rv_fe_overlap", 64'(both), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lin_resp_rx.md
Name: lin_resp_rx

Overview:
Commander-side LIN response receiver that sits downstream of lin_top and consumes its serial response line (sdo_resp). It deserialises the 9-byte response field (8 data bytes plus checksum, each framed start/8 data LSB-first/stop) and recovers data[63:0]. It recomputes the LIN checksum (classic or enhanced, the latter including the protected ID derived from pid), then flags checksum and framing errors. Runs in the sys_clk domain, so no synchroniser is used on the serial input.

Parameters:
CLKS_PER_BIT, 16, sys_clk cycles per LIN bit; must equal the bit period of the upstream transmitter; minimum 4
ENHANCED, 1, 1 = enhanced checksum (PID included), 0 = classic checksum (data bytes only)
TIMEOUT_BITS, 14, maximum idle bit-times allowed between a stop bit and the next start bit before the frame is aborted

Ports:
sys_clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
rx_en  in  1  level; arms the receiver while high; sampled only in IDLE
pid  in  6  frame identifier, used for the enhanced checksum; sampled when a start bit is detected in IDLE
sdo_resp  in  1  serial response line, idle high
data_out  out  64  received data; byte k occupies bits [8k+7:8k]; byte 0 is the first received
chk_out  out  8  received checksum byte
resp_valid  out  1  one-cycle pulse when a complete frame has been received
chk_err  out  1  valid with resp_valid; 1 = received checksum does not equal the computed one
frame_err  out  1  one-cycle pulse on a bad start bit, bad stop bit, or inter-byte timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; data_out=0, chk_out=0, resp_valid=0, chk_err=0, frame_err=0, busy=0; all counters and the checksum accumulator are cleared. Reset asserted mid-frame aborts the frame immediately, with no pulse.
- Falling edge detection: registered previous line value prev; edge = prev & ~sdo_resp. prev resets to 1.
- IDLE: if rx_en and edge, go to START. Latch pid, byte_idx=0, acc=0 (ENHANCED=1: acc=protected PID byte {P1,P0,pid}, where P0=id0^id1^id2^id4 and P1=~(id1^id3^id4^id5)).
- START: wait CLKS_PER_BIT/2 cycles, then sample the line. If 0, go to DATA with bit_idx=0. If 1, pulse frame_err and return to IDLE.
- DATA: sample every CLKS_PER_BIT cycles and shift right into the byte register, LSB first. After the 8th sample, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles. If 0, pulse frame_err and return to IDLE. If 1:
  - byte_idx<8: store the byte into data_out[8*byte_idx+:8], then acc = acc + byte with end-around carry (sum>255 means sum-255). Increment byte_idx and go to GAP.
  - byte_idx==8: chk_out=byte, chk_err=(byte != ~acc), pulse resp_valid the next cycle, and go to IDLE.
- GAP: on edge, go to START. Otherwise count cycles; at TIMEOUT_BITS*CLKS_PER_BIT cycles, pulse frame_err and return to IDLE.
- data_out is only updated byte-by-byte in STOP. It holds its last value otherwise and is not cleared on error.
- Latency: resp_valid is asserted exactly 1 cycle after the checksum stop-bit sample.
- Simultaneous events: rx_en deasserting mid-frame is ignored, because the frame completes. An edge in the same cycle a timeout expires is treated as a timeout. resp_valid and frame_err are never high together.
- Bit-time counter width: $clog2(TIMEOUT_BITS*CLKS_PER_BIT+1).

Test Plan:
1. rstn low 500 ns, then high; pid=6'h2d, data=64'd32639 sent by lin_top, ENHANCED=1 -> resp_valid pulses once, data_out=64'h0000_0000_0000_7F7F, chk_out=8'h53, chk_err=0, frame_err never high.
2. Same frame with ENHANCED=0 -> checksum 8'h01 accepted, chk_err=0. Repeat driving chk 8'h53 into the ENHANCED=0 instance -> chk_err=1.
3. Bench-driven frame with the 3rd byte's stop bit forced low -> frame_err pulse at that stop sample, state IDLE, no resp_valid, data_out bytes 0-1 updated.
4. 0.3-bit low glitch on idle line with rx_en=1 -> start sample reads 1, frame_err pulse, back to IDLE, busy low.
5. Line held high after byte 4 for 15 bit-times -> frame_err pulse at 14*CLKS_PER_BIT cycles after the stop sample. A 13-bit gap instead completes normally.
6. rstn pulsed low mid-byte 5 -> all outputs 0 asynchronously. The next full frame (pid=6'h2d, data=32639) is received correctly with chk_out=8'h53.
